// File: rtl/count_pair_ctrl_if.sv
// Control/status bundle for count_pair_ctrl: run controls in, counter state out.
interface count_pair_ctrl_if;
  logic       start;
  logic       pause;
  logic       abort;
  logic [3:0] x;
  logic [3:0] y;
  logic [1:0] phase;
  logic       busy;
  logic       done;

  modport master (
    output start, pause, abort,
    input  x, y, phase, busy, done
  );

  modport slave (
    input  start, pause, abort,
    output x, y, phase, busy, done
  );
endinterface

// File: rtl/count_pair_ctrl.sv
// Two-phase run controller: x counts to X_LIMIT, then y counts to Y_LIMIT,
// followed by a single-cycle DONE; supports pause, abort and async reset.
module count_pair_ctrl #(
  parameter int unsigned X_LIMIT = 3,
  parameter int unsigned Y_LIMIT = 5
) (
  input logic            clk,
  input logic            reset,
  count_pair_ctrl_if.slave bus
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] X_TERM = CW'(X_LIMIT);
  localparam logic [CW-1:0] Y_TERM = CW'(Y_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XRUN = 2'd1,
    YRUN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] x_inc, y_inc;

  assign x_inc = x_q + CW'(1);
  assign y_inc = y_q + CW'(1);

  // State and counter registers; busy/done are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and counter update; abort outranks pause, pause outranks start.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;

    if (bus.abort) begin
      state_d = IDLE;
      x_d     = '0;
      y_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          x_d = '0;
          y_d = '0;
          if (bus.start) begin
            state_d = XRUN;
          end
        end
        XRUN: begin
          y_d = '0;
          if (!bus.pause) begin
            x_d = x_inc;
            if (x_inc == X_TERM) begin
              state_d = YRUN;
            end
          end
        end
        YRUN: begin
          x_d = X_TERM;
          if (!bus.pause) begin
            y_d = y_inc;
            if (y_inc == Y_TERM) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          x_d     = '0;
          y_d     = '0;
        end
        default: begin
          state_d = IDLE;
          x_d     = '0;
          y_d     = '0;
        end
      endcase
    end

    busy_d = (state_d == XRUN) || (state_d == YRUN);
    done_d = (state_d == DONE);
  end

  assign bus.x     = x_q;
  assign bus.y     = y_q;
  assign bus.phase = state_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_count_pair_ctrl.sv
// Directed bench for count_pair_ctrl: vector table plus hand-written
// sequences for async reset, back-to-back runs and the X=1/Y=15 build.
module tb_count_pair_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  count_pair_ctrl_if ifa ();
  count_pair_ctrl_if ifb ();

  count_pair_ctrl dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  count_pair_ctrl #(.X_LIMIT(1), .Y_LIMIT(15)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  // Outputs packed as {x, y, phase, busy, done}
  logic [11:0] out_a, out_b;
  assign out_a = {ifa.x, ifa.y, ifa.phase, ifa.busy, ifa.done};
  assign out_b = {ifb.x, ifb.y, ifb.phase, ifb.busy, ifb.done};

  typedef struct {
    logic       start;
    logic       pause;
    logic       abort;
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] ph;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(logic s, logic p, logic a, int x, int y, int ph, logic b, logic d);
    vec_t v;
    v.start = s; v.pause = p; v.abort = a;
    v.x = 4'(x); v.y = 4'(y); v.ph = 2'(ph); v.busy = b; v.done = d;
    vecs.push_back(v);
  endfunction

  function automatic logic [11:0] pk(int x, int y, int ph, logic b, logic d);
    return {4'(x), 4'(y), 2'(ph), b, d};
  endfunction

  task automatic cmp(string name, logic [11:0] act, logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d ph=%0d busy=%0b done=%0b, want x=%0d y=%0d ph=%0d busy=%0b done=%0b",
               name, act[11:8], act[7:4], act[3:2], act[1], act[0],
               exp[11:8], exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  task automatic cmp_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Phase of the default build k edges after a start was sampled in IDLE,
  // with start held high (period X+Y+2 = 10).
  function automatic int exp_phase(int k);
    int m;
    m = k % 10;
    if (m < 3) return 1;
    if (m < 8) return 2;
    if (m == 8) return 3;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;

    reset = 1'b1;
    ifa.start = 1'b0; ifa.pause = 1'b0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.pause = 1'b0; ifb.abort = 1'b0;
    #1;
    cmp("reset_a", out_a, pk(0, 0, 0, 1'b0, 1'b0));
    cmp("reset_b", out_b, pk(0, 0, 0, 1'b0, 1'b0));
    tick();
    tick();
    reset = 1'b0;

    // Idle hold
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // Nominal run
    add(1, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 2, 0, 1, 1, 0);
    add(0, 0, 0, 3, 0, 2, 1, 0);
    for (int k = 1; k <= 4; k++) add(0, 0, 0, 3, k, 2, 1, 0);
    add(0, 0, 0, 3, 5, 3, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // Pause for two cycles at x=2; pause on the DONE edge is ignored
    add(1, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 2, 0, 1, 1, 0);
    add(0, 1, 0, 2, 0, 1, 1, 0);
    add(0, 1, 0, 2, 0, 1, 1, 0);
    add(0, 0, 0, 3, 0, 2, 1, 0);
    for (int k = 1; k <= 4; k++) add(0, 0, 0, 3, k, 2, 1, 0);
    add(0, 0, 0, 3, 5, 3, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    // Abort at y=3
    add(1, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 2, 0, 1, 1, 0);
    add(0, 0, 0, 3, 0, 2, 1, 0);
    for (int k = 1; k <= 3; k++) add(0, 0, 0, 3, k, 2, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // Abort beats simultaneous pause and start
    add(1, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0);
    // Pause on both terminal edges; start in DONE and during busy ignored
    add(1, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 2, 0, 1, 1, 0);
    add(0, 1, 0, 2, 0, 1, 1, 0);
    add(0, 0, 0, 3, 0, 2, 1, 0);
    for (int k = 1; k <= 4; k++) add(0, 0, 0, 3, k, 2, 1, 0);
    add(0, 1, 0, 3, 4, 2, 1, 0);
    add(0, 0, 0, 3, 5, 3, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 1, 0);
    add(1, 0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 2, 0, 1, 1, 0);
    add(1, 0, 0, 3, 0, 2, 1, 0);
    add(1, 0, 0, 3, 1, 2, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      ifa.start = vecs[i].start;
      ifa.pause = vecs[i].pause;
      ifa.abort = vecs[i].abort;
      tick();
      cmp($sformatf("vec%0d", i), out_a,
          {vecs[i].x, vecs[i].y, vecs[i].ph, vecs[i].busy, vecs[i].done});
    end
    ifa.start = 1'b0; ifa.pause = 1'b0; ifa.abort = 1'b0;

    // Async reset mid-period at x=2, held across an edge with start high
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    tick();
    tick();
    cmp("pre_reset", out_a, pk(2, 0, 1, 1'b1, 1'b0));
    #3;
    reset = 1'b1;
    #1;
    cmp("async_reset", out_a, pk(0, 0, 0, 1'b0, 1'b0));
    ifa.start = 1'b1;
    tick();
    cmp("reset_hold", out_a, pk(0, 0, 0, 1'b0, 1'b0));
    reset = 1'b0;
    ifa.start = 1'b0;
    tick();
    cmp("post_release_idle", out_a, pk(0, 0, 0, 1'b0, 1'b0));

    // Full run after reset release
    busy_cnt = 0;
    done_cnt = 0;
    ifa.start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      ifa.start = 1'b0;
      if (ifa.busy) busy_cnt++;
      if (ifa.done) done_cnt++;
      if (k == 2) cmp("rerun_x2", out_a, pk(2, 0, 1, 1'b1, 1'b0));
      if (k == 8) cmp("rerun_done", out_a, pk(3, 5, 3, 1'b0, 1'b1));
    end
    cmp_int("rerun_busy_cycles", busy_cnt, 8);
    cmp_int("rerun_done_cycles", done_cnt, 1);
    cmp("rerun_idle", out_a, pk(0, 0, 0, 1'b0, 1'b0));

    // Back-to-back with start held high for three runs
    ifa.start = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (ifa.busy) busy_cnt++;
      cmp_int($sformatf("b2b_phase%0d", k), int'(ifa.phase), exp_phase(k));
    end
    ifa.start = 1'b0;
    cmp_int("b2b_busy_cycles", busy_cnt, 24);
    tick();
    cmp("b2b_idle_after", out_a, pk(0, 0, 0, 1'b0, 1'b0));

    // X_LIMIT=1, Y_LIMIT=15 build
    busy_cnt = 0;
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    if (ifb.busy) busy_cnt++;
    cmp("b_xrun", out_b, pk(0, 0, 1, 1'b1, 1'b0));
    tick();
    if (ifb.busy) busy_cnt++;
    cmp("b_yrun_entry", out_b, pk(1, 0, 2, 1'b1, 1'b0));
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (ifb.busy) busy_cnt++;
      cmp($sformatf("b_y%0d", k), out_b, pk(1, k, 2, 1'b1, 1'b0));
    end
    tick();
    if (ifb.busy) busy_cnt++;
    cmp("b_done", out_b, pk(1, 15, 3, 1'b0, 1'b1));
    tick();
    cmp("b_idle", out_b, pk(0, 0, 0, 1'b0, 1'b0));
    cmp_int("b_busy_cycles", busy_cnt, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/count_pair_ctrl.md
COUNT_PAIR_CTRL -- requirements
Module: count_pair_ctrl

Interface
REQ-001 The parameter list SHALL be: X_LIMIT, default 3, x terminal value (legal 1..15).
REQ-002 The parameter list SHALL include Y_LIMIT, default 5, y terminal value (legal 1..15).
REQ-003 Port clk SHALL be an input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit, asynchronous, active-high reset.
REQ-005 Port start SHALL be an input, 1 bit, a run request sampled in IDLE.
REQ-006 Port pause SHALL be an input, 1 bit, which freezes the counters and state while running.
REQ-007 Port abort SHALL be an input, 1 bit, a synchronous cancel back to IDLE.
REQ-008 Port x SHALL be an output, 4 bits, the first-phase counter value.
REQ-009 Port y SHALL be an output, 4 bits, the second-phase counter value.
REQ-010 Port phase SHALL be an output, 2 bits, the state code: IDLE=0, XRUN=1, YRUN=2, DONE=3.
REQ-011 Port busy SHALL be an output, 1 bit, high in XRUN or YRUN.
REQ-012 Port done SHALL be an output, 1 bit, high only in DONE.

Function
REQ-013 x, y, phase, busy and done SHALL all be registered; no output SHALL depend combinationally on the inputs.
REQ-014 IDLE: x=0, y=0; start=1 at an edge -> XRUN after that edge, with x=0 and y=0.
REQ-015 XRUN: y SHALL be forced to 0; on each edge with pause=0, x<=x+1.
REQ-016 XRUN: the edge on which x+1==X_LIMIT SHALL load x=X_LIMIT and move to YRUN.
REQ-017 YRUN: x SHALL hold at X_LIMIT; on each edge with pause=0, y<=y+1.
REQ-018 YRUN: the edge on which y+1==Y_LIMIT SHALL load y=Y_LIMIT and move to DONE.
REQ-019 DONE SHALL last exactly one cycle with x=X_LIMIT, y=Y_LIMIT and done=1; the next edge -> IDLE with x=0 and y=0.
REQ-020 With no pause, busy SHALL be high for exactly X_LIMIT+Y_LIMIT cycles per run.
REQ-021 pause=1 in XRUN or YRUN SHALL hold x, y and the state unchanged; pause SHALL be ignored in IDLE and DONE.
REQ-022 Neither counter SHALL ever wrap; the arithmetic is 4-bit unsigned, and the legal limits guarantee the terminal value is reached before overflow.
REQ-023 start SHALL be ignored in XRUN, YRUN and DONE; a new run requires start to be sampled in IDLE.
REQ-024 start held high continuously SHALL begin a new run on the first edge after the DONE->IDLE return, giving one IDLE cycle between runs.
REQ-025 abort=1 in any state SHALL force IDLE with x=0 and y=0 on the next edge, with no done pulse.
REQ-026 Priority on simultaneous inputs SHALL be abort > pause > start.
REQ-027 A terminal-count edge coinciding with pause=1 SHALL NOT advance; the transition occurs on the first un-paused edge.

Reset
REQ-028 reset=1 SHALL immediately, without waiting for a clock edge, set phase=IDLE, x=0, y=0, busy=0 and done=0.
REQ-029 Reset asserted mid-run SHALL discard the run; after release the block SHALL wait in IDLE for start.
REQ-030 Release of reset SHALL take effect synchronously on the next clk edge; no state change occurs while reset=1.

Verification
REQ-031 Nominal run, defaults: start pulse at edge E0 -> x=1,2,3 at E1..E3, YRUN entered at E3, y=1..5 at E4..E8, done=1 for exactly one cycle after E8, IDLE with x=y=0 after E9.
REQ-032 Pause: pause=1 for 2 cycles while x=2 in XRUN -> x stays 2 and phase stays 1 for those 2 cycles, then the run resumes and busy totals 10 cycles.
REQ-033 Abort: abort=1 at y=3 in YRUN -> next cycle phase=0, x=0, y=0, done never asserted.
REQ-034 Async reset: reset asserted mid-clock-period at x=2 -> outputs are 0 before the next edge; start after release gives a full nominal run.
REQ-035 Back-to-back: start held high -> runs are separated by exactly one IDLE cycle; start pulses during busy have no effect.
REQ-036 Parameters X_LIMIT=1 and Y_LIMIT=15 -> one XRUN cycle, then y counts to 15 without wrap; done=1 with x=1 and y=15.
